// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder.
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic             done;

  modport master (output start, a, b, cin, input  sum, cout, busy, done);
  modport slave  (input  start, a, b, cin, output sum, cout, busy, done);
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice, LSB first, WIDTH shift cycles per add.
// Result registers update only on the SHIFT->DONE edge, so no partial sum is ever visible.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next, sum_q;
  logic             c, c_next, bit_s, cout_q, busy_q, done_q;
  logic [CW-1:0]    cnt;

  always_comb begin
    bit_s    = a_sr[0] ^ b_sr[0] ^ c;
    c_next   = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
    res_next = res_sr >> 1;
    res_next[WIDTH-1] = bit_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            c      <= bus.cin;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          c      <= c_next;
          cnt    <= cnt + CW'(1);
          // cnt counts completed bit pairs; this edge finishes the last one
          if (cnt == CW'(WIDTH - 1)) begin
            sum_q  <= res_next;
            cout_q <= c_next;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_serial_adder.sv
// Random and directed checks of serial_adder at WIDTH=8 plus exhaustive WIDTH=1.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) b8 ();
  serial_adder_if #(.WIDTH(1)) b1 ();

  serial_adder #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(b8));
  serial_adder #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .bus(b1));

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] last_sum;
  logic       last_cout;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One WIDTH=8 operation; optionally scramble inputs and re-pulse start while it runs.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci, input bit scramble);
    logic [8:0] exp;
    int busy_cnt, done_cnt, done_cyc;
    bit hold_ok, overlap;
    exp = 9'(a) + 9'(b) + 9'(ci);
    @(negedge clk);
    b8.start = 1'b1; b8.a = a; b8.b = b; b8.cin = ci;
    @(negedge clk);
    b8.start = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_cyc = 0; hold_ok = 1; overlap = 0;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      if (b8.busy) busy_cnt++;
      if (b8.busy && b8.done) overlap = 1;
      if (b8.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (done_cnt == 0 && (b8.sum !== last_sum || b8.cout !== last_cout)) hold_ok = 0;
      if (done_cnt != 0 && (b8.sum !== exp[7:0] || b8.cout !== exp[8])) hold_ok = 0;
      if (scramble && cyc <= 9) begin
        b8.start = 1'($urandom);
        b8.a = 8'($urandom); b8.b = 8'($urandom); b8.cin = 1'($urandom);
      end else begin
        b8.start = 1'b0;
      end
      @(negedge clk);
    end
    chk("busy_cycles", 64'(busy_cnt), 64'd8);
    chk("done_cycle", 64'(done_cyc), 64'd9);
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("busy_done_overlap", 64'(overlap), 64'd0);
    chk("result_hold", 64'(hold_ok), 64'd1);
    chk("sum", 64'(b8.sum), 64'(exp[7:0]));
    chk("cout", 64'(b8.cout), 64'(exp[8]));
    last_sum = exp[7:0]; last_cout = exp[8];
  endtask

  task automatic run1(input logic a, input logic b, input logic ci);
    logic [1:0] exp;
    int done_cyc;
    exp = 2'(a) + 2'(b) + 2'(ci);
    done_cyc = 0;
    @(negedge clk);
    b1.start = 1'b1; b1.a = a; b1.b = b; b1.cin = ci;
    @(negedge clk);
    b1.start = 1'b0;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      if (b1.done && done_cyc == 0) done_cyc = cyc;
      @(negedge clk);
    end
    chk("w1_done_cycle", 64'(done_cyc), 64'd2);
    chk("w1_result", 64'({b1.cout, b1.sum}), 64'(exp));
  endtask

  initial begin
    int dones[$];
    logic [8:0] exp;
    bit stable;
    rst = 1'b1;
    b8.start = 0; b8.a = 0; b8.b = 0; b8.cin = 0;
    b1.start = 0; b1.a = 0; b1.b = 0; b1.cin = 0;
    repeat (2) @(negedge clk);
    b8.start = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(b8.busy), 64'd0);
    chk("rst_done", 64'(b8.done), 64'd0);
    chk("rst_sum", 64'(b8.sum), 64'd0);
    chk("rst_cout", 64'(b8.cout), 64'd0);
    b8.start = 1'b0;
    rst = 1'b0;
    last_sum = 8'h00; last_cout = 1'b0;

    run8(8'h3C, 8'h42, 1'b0, 0);
    run8(8'hFF, 8'h01, 1'b0, 0);
    run8(8'hA5, 8'h5A, 1'b1, 0);
    run8(8'h00, 8'h00, 1'b0, 0);
    run8(8'hFF, 8'hFF, 1'b1, 1);
    for (int i = 0; i < 16; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom), bit'(i[0]));

    // start held high: back-to-back operations every WIDTH+2 cycles
    exp = 9'h5C + 9'h7B + 9'd1;
    @(negedge clk);
    b8.start = 1'b1; b8.a = 8'h5C; b8.b = 8'h7B; b8.cin = 1'b1;
    stable = 1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (b8.done) dones.push_back(cyc);
      if (dones.size() > 0 && (b8.sum !== exp[7:0] || b8.cout !== exp[8])) stable = 0;
    end
    b8.start = 1'b0;
    chk("held_done_count", 64'(dones.size()), 64'd4);
    chk("held_first_done", 64'(dones.size() > 0 ? dones[0] : 0), 64'd9);
    for (int i = 1; i < dones.size(); i++)
      chk("held_period", 64'(dones[i] - dones[i-1]), 64'd10);
    chk("held_stable", 64'(stable), 64'd1);
    repeat (12) @(negedge clk);
    last_sum = exp[7:0]; last_cout = exp[8];

    // reset during the 4th SHIFT cycle aborts with no done pulse
    b8.start = 1'b1; b8.a = 8'h81; b8.b = 8'h93; b8.cin = 1'b0;
    @(negedge clk);
    b8.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort_busy", 64'(b8.busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(b8.busy), 64'd0);
    chk("abort_done", 64'(b8.done), 64'd0);
    chk("abort_sum", 64'(b8.sum), 64'd0);
    chk("abort_cout", 64'(b8.cout), 64'd0);
    stable = 1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (b8.done || b8.busy) stable = 0;
      @(negedge clk);
    end
    chk("abort_no_done", 64'(stable), 64'd1);
    last_sum = 8'h00; last_cout = 1'b0;
    run8(8'hC7, 8'h4E, 1'b1, 0);

    for (int v = 0; v < 8; v++) begin
      logic [2:0] vv;
      vv = 3'(v);
      run1(vv[2], vv[1], vv[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
